// File: rtl/serial_crc_ccitt_pkg.sv
// Shared CRC-16/CCITT-FALSE constants and a one-bit step function.
// Checkers and scoreboards can reuse crc_ccitt_step.
package crc_pkg;

    localparam int          CCITT_W    = 16;
    localparam logic [15:0] CCITT_POLY = 16'h1021;
    localparam logic [15:0] CCITT_SEED = 16'hFFFF;

    function automatic logic [15:0] crc_ccitt_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? CCITT_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/serial_crc_ccitt_lfsr_stage.sv
// Combinational next remainder for one MSB-first input bit of a Galois-form CRC.
module crc_lfsr_stage #(
    parameter int               CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h1021
) (
    input  logic [CRC_W-1:0] i_crc,
    input  logic             i_bit,
    output logic [CRC_W-1:0] o_crc
);

    logic w_fb;

    assign w_fb  = i_bit ^ i_crc[CRC_W-1];
    assign o_crc = {i_crc[CRC_W-2:0], 1'b0} ^ ({CRC_W{w_fb}} & POLY);

endmodule

// File: rtl/serial_crc_ccitt.sv
// Bit-serial CRC-16/CCITT-FALSE generator/checker; crc_out is the running remainder.
module serial_crc_ccitt
    import crc_pkg::*;
#(
    parameter int               CRC_W = CCITT_W,
    parameter logic [CRC_W-1:0] POLY  = CCITT_POLY,
    parameter logic [CRC_W-1:0] SEED  = CCITT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             init,
    input  logic             data_in,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] w_crc_next;

    crc_lfsr_stage #(
        .CRC_W (CRC_W),
        .POLY  (POLY)
    ) u_stage (
        .i_crc (r_crc),
        .i_bit (data_in),
        .o_crc (w_crc_next)
    );

    // init outranks enable, so a bit presented alongside init is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_crc <= SEED;
        end else if (init) begin
            r_crc <= SEED;
        end else if (enable) begin
            r_crc <= w_crc_next;
        end
    end

    assign crc_out = r_crc;

endmodule

// File: tb/tb_serial_crc_ccitt.sv
// Self-checking bench for serial_crc_ccitt: vector table, known string, gating, reset/init, random frames.
module tb_serial_crc_ccitt;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        init;
    logic        data_in;
    logic [15:0] crc_out;

    int checks;
    int errors;

    serial_crc_ccitt dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .init    (init),
        .data_in (data_in),
        .crc_out (crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ini;
        logic        din;
        logic [15:0] exp;
    } vec_t;

    vec_t  tbl[8];
    bit    hist[$];
    string msg;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic cyc(input logic en, input logic ini, input logic d);
        enable  = en;
        init    = ini;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Reference: remainder of (M(x)*x^16 + SEED(x)*x^n) mod P(x) by explicit long division.
    function automatic logic [15:0] ref_crc(input bit m[$]);
        bit          a[$];
        int          n;
        logic [16:0] p17;
        logic [15:0] r;
        n   = m.size();
        p17 = 17'h11021;
        a   = m;
        for (int k = 0; k < 16; k++) a.push_back(1'b0);
        for (int k = 0; k < 16; k++) a[k] = a[k] ^ 1'b1;
        for (int i = 0; i < n; i++) begin
            if (a[i]) begin
                for (int j = 0; j <= 16; j++) a[i+j] = a[i+j] ^ p17[16-j];
            end
        end
        for (int k = 0; k < 16; k++) r[15-k] = a[n+k];
        return r;
    endfunction

    task automatic feed_string(input int nbits);
        logic [7:0] b;
        for (int i = 0; i < nbits; i++) begin
            b = msg[i/8];
            cyc(1'b1, 1'b0, b[7 - (i % 8)]);
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] c;
        logic        d;
        checks  = 0;
        errors  = 0;
        msg     = "123456789";
        enable  = 1'b0;
        init    = 1'b0;
        data_in = 1'b0;
        reset   = 1'b1;

        // asynchronous reset before any clock edge
        #1 reset = 1'b0;
        #1 check("reset_async", crc_out, 16'hFFFF);
        @(posedge clk); #1;
        check("reset_held", crc_out, 16'hFFFF);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("reset_release_idle", crc_out, 16'hFFFF);

        tbl[0] = '{1'b1, 1'b0, 1'b1, 16'hFFFE};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 16'hFFFF};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 16'hEFDF};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 16'hEFDF};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 16'hFFFF};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'hEFDF};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 16'hDFBE};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 16'hDFBE};
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].en, tbl[i].ini, tbl[i].din);
            check($sformatf("table_%0d", i), crc_out, tbl[i].exp);
        end

        // known vector
        cyc(1'b0, 1'b1, 1'b0);
        feed_string(72);
        check("known_123456789", crc_out, 16'h29B1);

        // enable gating with random data on idle cycles
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 72; i++) begin
            while ($urandom_range(0, 2) == 0) begin
                c = crc_out;
                cyc(1'b0, 1'b0, 1'($urandom));
                check("gated_hold", crc_out, c);
            end
            b = msg[i/8];
            cyc(1'b1, 1'b0, b[7 - (i % 8)]);
        end
        check("gated_known", crc_out, 16'h29B1);

        // init mid-stream with enable high, then restart the frame
        cyc(1'b0, 1'b1, 1'b0);
        feed_string(20);
        cyc(1'b1, 1'b1, 1'($urandom));
        check("init_midstream", crc_out, 16'hFFFF);
        feed_string(72);
        check("init_restart_known", crc_out, 16'h29B1);

        // reset mid-stream aborts, next frame needs no init
        cyc(1'b0, 1'b1, 1'b0);
        feed_string(30);
        #2 reset = 1'b0;
        #1 check("reset_midstream_async", crc_out, 16'hFFFF);
        enable  = 1'b1;
        data_in = 1'b0;
        @(posedge clk); #1;
        check("reset_midstream_held", crc_out, 16'hFFFF);
        reset = 1'b1;
        feed_string(72);
        check("reset_restart_known", crc_out, 16'h29B1);

        // random frame checked every bit, then appended CRC must leave zero
        cyc(1'b0, 1'b1, 1'b0);
        hist.delete();
        for (int i = 0; i < 40; i++) begin
            d = 1'($urandom);
            cyc(1'b1, 1'b0, d);
            hist.push_back(d);
            check($sformatf("random_bit_%0d", i), crc_out, ref_crc(hist));
        end
        c = ref_crc(hist);
        for (int k = 15; k >= 0; k--) begin
            cyc(1'b1, 1'b0, c[k]);
            hist.push_back(c[k]);
            check("random_append", crc_out, ref_crc(hist));
        end
        check("random_residue_zero", crc_out, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
